piece_queue: RTL

PIECE_QUEUE -- requirements
Module: piece_queue

---
 rtl/piece_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/piece_queue.sv
// piece_queue: LFSR-driven piece generator feeding a short FIFO whose head
// and look-ahead entries are exposed as registered outputs.
// Optional 7-bag mode (each type once per group of 7) is enabled by defining
// the macro PIECE_QUEUE_BAG_EN; the default build draws every candidate.
module piece_queue #(
  parameter int unsigned PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed_load,
  input  logic [15:0]                  seed,
  input  logic                         next_req,
  output logic [2:0]                   piece_out,
  output logic                         piece_valid,
  output logic [3*PREVIEW_DEPTH-1:0]   preview,
  output logic [PREVIEW_DEPTH-1:0]     preview_valid,
  output logic                         queue_full
);

  localparam int unsigned QD = PREVIEW_DEPTH + 1;
  localparam int unsigned CW = $clog2(QD + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QD);

  // Architectural state
  logic [15:0]   r_lfsr;
  logic [2:0]    r_q [QD];
  logic [QD-1:0] r_v;
  logic [CW-1:0] r_cnt;
  logic          r_full;

  // Next-state values
  logic [15:0]   w_lfsr_nxt;
  logic [2:0]    w_q_nxt [QD];
  logic [QD-1:0] w_v_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_full_nxt;

  // Per-cycle decisions
  logic [2:0]    w_cand;
  logic [2:0]    w_type;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_wr_idx;
  logic          w_fb;

`ifdef PIECE_QUEUE_BAG_EN
  logic [6:0]    r_bag;
  logic [6:0]    w_bag_nxt;
  logic [6:0]    w_cand_bit;
  logic [6:0]    w_bag_set;
`endif

  // Candidate is the LFSR low bits before this cycle's step; decide acceptance
  always_comb begin
    w_cand = r_lfsr[2:0];
`ifdef PIECE_QUEUE_BAG_EN
    w_cand_bit = 7'd1 << w_cand;
    w_accept   = (w_cand != 3'd7) && ((r_bag & w_cand_bit) == 7'd0);
    w_type     = w_cand;
`else
    w_accept   = 1'b1;
    w_type     = (w_cand == 3'd7) ? 3'd0 : w_cand;
`endif
  end

  // Pop/push qualification; a reseed cycle suppresses both
  always_comb begin
    w_pop  = next_req && (r_cnt != '0) && !seed_load;
    w_push = w_accept && ((r_cnt != FULL_CNT) || w_pop) && !seed_load;
  end

  // LFSR next value: reseed (zero seed substituted) or Fibonacci step
  always_comb begin
    w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    w_lfsr_nxt = {r_lfsr[14:0], w_fb};
    if (seed_load) begin
      w_lfsr_nxt = (seed == 16'd0) ? SEED : seed;
    end
  end

`ifdef PIECE_QUEUE_BAG_EN
  // Bag mask: mark pushed types, clear once all seven have been used
  always_comb begin
    w_bag_set = r_bag | w_cand_bit;
    w_bag_nxt = r_bag;
    if (seed_load) begin
      w_bag_nxt = 7'd0;
    end else if (w_push) begin
      w_bag_nxt = (w_bag_set == 7'h7F) ? 7'd0 : w_bag_set;
    end
  end
`endif

  // FIFO next contents: shift toward head on pop, write at tail on push
  always_comb begin
    w_q_nxt  = r_q;
    w_v_nxt  = r_v;
    w_wr_idx = r_cnt - CW'(w_pop);
    if (w_pop) begin
      for (int unsigned i = 0; i + 1 < QD; i++) begin
        w_q_nxt[i] = r_q[i+1];
        w_v_nxt[i] = r_v[i+1];
      end
      w_q_nxt[QD-1] = 3'd0;
      w_v_nxt[QD-1] = 1'b0;
    end
    if (w_push) begin
      for (int unsigned i = 0; i < QD; i++) begin
        if (CW'(i) == w_wr_idx) begin
          w_q_nxt[i] = w_type;
          w_v_nxt[i] = 1'b1;
        end
      end
    end
    if (seed_load) begin
      for (int unsigned i = 0; i < QD; i++) begin
        w_q_nxt[i] = 3'd0;
      end
      w_v_nxt = '0;
    end
  end

  // Occupancy and full flag
  always_comb begin
    w_cnt_nxt = r_cnt - CW'(w_pop) + CW'(w_push);
    if (seed_load) begin
      w_cnt_nxt = '0;
    end
    w_full_nxt = (w_cnt_nxt == FULL_CNT);
  end

  // State registers; reset discards the queue immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
      for (int unsigned i = 0; i < QD; i++) begin
        r_q[i] <= 3'd0;
      end
      r_v    <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_q    <= w_q_nxt;
      r_v    <= w_v_nxt;
      r_cnt  <= w_cnt_nxt;
      r_full <= w_full_nxt;
    end
  end

`ifdef PIECE_QUEUE_BAG_EN
  // Bag mask register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bag <= 7'd0;
    end else begin
      r_bag <= w_bag_nxt;
    end
  end
`endif

  // Outputs are direct views of the queue flops
  assign piece_out   = r_q[0];
  assign piece_valid = r_v[0];
  assign queue_full  = r_full;

  for (genvar gi = 0; gi < int'(PREVIEW_DEPTH); gi++) begin : g_prev
    assign preview[3*gi +: 3] = r_q[gi+1];
    assign preview_valid[gi]  = r_v[gi+1];
  end

endmodule
